ad7960_responder: RTL and testbench
===================================

AD7960_RESPONDER -- requirements
Module: ad7960_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 18, sample width.
REQ-002 SHALL have parameter TCONV_CYC, default 36, fast_clk_i cycles from CNV rise to data ready.
REQ-003 SHALL have port fast_clk_i  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port buffer_reset_s  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cnv_i  input  1  convert request, single-ended.
REQ-006 SHALL have port clk_en_i  input  1  serial clock enable; one bit per enabled cycle.
REQ-007 SHALL have port sample_data_i  input  DATA_W  value to convert.
REQ-008 SHALL have port d_o  output  1  serial data, MSB first.
REQ-009 SHALL have port dco_o  output  1  echoed clock.
REQ-010 SHALL have port busy_o  output  1  high while converting.
REQ-011 SHALL have port sample_taken_o  output  1  one-cycle pulse on accepted CNV rise.
REQ-012 SHALL have port overrun_o  output  1  sticky; CNV rise before 18 bits were read.

Function
REQ-013 SHALL implement states IDLE, CONV, READY, SHIFT.
REQ-014 SHALL register cnv_i and detect its rising edge (1-cycle detection latency).
REQ-015 In IDLE, a CNV rise SHALL capture sample_data_i into conv_reg, pulse sample_taken_o, load the conversion counter with TCONV_CYC-1, and enter CONV.
REQ-016 In CONV, busy_o SHALL be 1; when the counter reaches 0, conv_reg SHALL load shift_reg, bit_cnt SHALL load DATA_W, and the FSM SHALL enter READY.
REQ-017 In READY or SHIFT with clk_en_i=1 and bit_cnt>0: d_o <= shift_reg[MSB], shift_reg shifts left with 0 fill, bit_cnt decrements, and the FSM enters SHIFT.
REQ-018 dco_o SHALL equal dco_q AND NOT fast_clk_i, where dco_q is clk_en_i registered in READY/SHIFT; dco_o therefore rises half a cycle after d_o settles.
REQ-019 When bit_cnt reaches 0, the FSM SHALL return to IDLE; d_o SHALL be 0 from the next cycle.
REQ-020 Extra clk_en_i in IDLE or CONV SHALL echo no dco_o and keep d_o=0.
REQ-021 A CNV rise during CONV SHALL be ignored and SHALL set overrun_o.
REQ-022 A CNV rise during READY or SHIFT SHALL set overrun_o, drop the remaining bits, and restart per REQ-015.
REQ-023 CNV rise and clk_en_i in the same cycle SHALL give priority to the CNV rise.
REQ-024 A TCONV_CYC of 0 SHALL behave as 1.

Reset
REQ-025 buffer_reset_s=1 SHALL asynchronously force: state IDLE, d_o=0, dco_q=0, busy_o=0, sample_taken_o=0, overrun_o=0, all registers 0, cnv edge register 0.
REQ-026 A reset asserted mid-SHIFT SHALL abort the transfer with no further dco_o pulses; the first CNV rise after release SHALL behave per REQ-015.

Configuration
REQ-027 With macro AD7960_TESTPATTERN_EN defined, conv_reg SHALL load an internal DATA_W counter instead of sample_data_i. The counter SHALL be 0 after reset, increment after each accepted conversion, and wrap from 0x3FFFF to 0.
REQ-028 Without the macro, sample_data_i SHALL be used and no pattern counter SHALL exist.

Structure
REQ-029 Package ad7960_pkg SHALL hold the state encoding, the DATA_W default and the TCONV_CYC default.
REQ-030 The shift_reg/bit_cnt/d_o/dco logic SHALL reside in sub-module ad7960_tx_shifter; the FSM and conversion timer SHALL remain top-level.

Verification
REQ-031 Load sample_data_i=0x2A5C3, pulse CNV, wait TCONV_CYC cycles, then drive 18 consecutive clk_en_i cycles -> 18 dco_o rises sampling 10_1010_0101_1100_0011, then IDLE.
REQ-032 CNV pulse, then 10 clocks, then a second CNV pulse -> overrun_o=1, sample_taken_o pulses, and a fresh 18-bit word is delivered.
REQ-033 Drive 20 clk_en_i cycles after data ready -> exactly 18 dco_o pulses, d_o=0 afterwards.
REQ-034 Assert buffer_reset_s after bit 7 -> all outputs 0 immediately; the next CNV yields a correct full word.
REQ-035 With AD7960_TESTPATTERN_EN defined, run 3 conversions -> words 0, 1, 2; force the counter to 0x3FFFF -> next words 0x3FFFF then 0.
REQ-036 Drive a CNV rise and clk_en_i in the same cycle during READY -> no bit shifted, restart, overrun_o=1.

Source files
------------

// File: rtl/ad7960_pkg.sv
// ad7960_responder shared types: FSM encoding and parameter defaults.
// Optional build macro: AD7960_TESTPATTERN_EN (internal counter as sample).
package ad7960_pkg;

  localparam int DATA_W_DEF    = 18;
  localparam int TCONV_CYC_DEF = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    READY = 2'd2,
    SHIFT = 2'd3
  } state_t;

  // A zero conversion time still spends one cycle in CONV.
  function automatic int tconv_load(int tc);
    return (tc < 1) ? 0 : tc - 1;
  endfunction

endpackage

// File: rtl/ad7960_tx_shifter.sv
// Serial output path: shift register, bit counter, d_o and echoed clock.
// Optional build macro: AD7960_TESTPATTERN_EN (handled in the top).
module ad7960_tx_shifter #(
  parameter int DATA_W = 18
) (
  input  logic              fast_clk_i,
  input  logic              buffer_reset_s,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              active,
  input  logic              clk_en_i,
  output logic              d_o,
  output logic              dco_o,
  output logic              last
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_reg;
  logic [CW-1:0]     bit_cnt;
  logic              dco_q;
  logic              shift_en;

  assign shift_en = active & clk_en_i & (bit_cnt != '0);
  assign last     = shift_en & (bit_cnt == CW'(1));

  always_ff @(posedge fast_clk_i or posedge buffer_reset_s) begin
    if (buffer_reset_s) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      d_o       <= 1'b0;
      dco_q     <= 1'b0;
    end else begin
      dco_q <= shift_en;
      if (load) begin
        shift_reg <= load_data;
        bit_cnt   <= CW'(DATA_W);
        d_o       <= 1'b0;
      end else if (shift_en) begin
        d_o       <= shift_reg[DATA_W-1];
        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        bit_cnt   <= bit_cnt - 1'b1;
      end else if (!active) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        d_o       <= 1'b0;
      end
    end
  end

  // Echo rises mid-cycle, after d_o has settled.
  assign dco_o = dco_q & ~fast_clk_i;

endmodule

// File: rtl/ad7960_responder.sv
// AD7960-style ADC responder: CNV-triggered conversion, serial readout.
// Optional build macro: AD7960_TESTPATTERN_EN (counter replaces sample_data_i).
module ad7960_responder
  import ad7960_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TCONV_CYC = TCONV_CYC_DEF
) (
  input  logic              fast_clk_i,
  input  logic              buffer_reset_s,
  input  logic              cnv_i,
  input  logic              clk_en_i,
  input  logic [DATA_W-1:0] sample_data_i,
  output logic              d_o,
  output logic              dco_o,
  output logic              busy_o,
  output logic              sample_taken_o,
  output logic              overrun_o
);

  localparam int TW = $clog2(TCONV_CYC + 2);
  localparam logic [TW-1:0] TLOAD = TW'(tconv_load(TCONV_CYC));

  state_t            state, state_nx;
  logic              cnv_q, cnv_qq;
  logic              cnv_rise, accept, conv_done, active, last;
  logic [TW-1:0]     conv_cnt;
  logic [DATA_W-1:0] conv_reg, cap_data;

  assign cnv_rise  = cnv_q & ~cnv_qq;
  assign accept    = cnv_rise & (state != CONV);
  assign conv_done = (state == CONV) & (conv_cnt == '0);
  assign active    = ((state == READY) | (state == SHIFT)) & ~cnv_rise;
  assign busy_o    = (state == CONV);

`ifdef AD7960_TESTPATTERN_EN
  logic [DATA_W-1:0] pat_cnt;
  logic              unused_sample;

  assign unused_sample = ^sample_data_i;
  assign cap_data      = pat_cnt;

  always_ff @(posedge fast_clk_i or posedge buffer_reset_s) begin
    if (buffer_reset_s) pat_cnt <= '0;
    else if (accept)    pat_cnt <= pat_cnt + 1'b1;
  end
`else
  assign cap_data = sample_data_i;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = CONV;
      CONV:  if (conv_done) state_nx = READY;
      READY,
      SHIFT: begin
        if (accept)        state_nx = CONV;
        else if (last)     state_nx = IDLE;
        else if (clk_en_i) state_nx = SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge fast_clk_i or posedge buffer_reset_s) begin
    if (buffer_reset_s) begin
      state          <= IDLE;
      cnv_q          <= 1'b0;
      cnv_qq         <= 1'b0;
      conv_cnt       <= '0;
      conv_reg       <= '0;
      sample_taken_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      state          <= state_nx;
      cnv_q          <= cnv_i;
      cnv_qq         <= cnv_q;
      sample_taken_o <= accept;
      if (cnv_rise && state != IDLE) overrun_o <= 1'b1;
      if (accept) begin
        conv_reg <= cap_data;
        conv_cnt <= TLOAD;
      end else if (state == CONV && conv_cnt != '0) begin
        conv_cnt <= conv_cnt - 1'b1;
      end
    end
  end

  ad7960_tx_shifter #(.DATA_W(DATA_W)) u_tx (
    .fast_clk_i     (fast_clk_i),
    .buffer_reset_s (buffer_reset_s),
    .load           (conv_done),
    .load_data      (conv_reg),
    .active         (active),
    .clk_en_i       (clk_en_i),
    .d_o            (d_o),
    .dco_o          (dco_o),
    .last           (last)
  );

endmodule

// File: tb/tb_ad7960_responder.sv
// Self-checking bench for ad7960_responder: vector table plus corner sequences.
// Build with AD7960_TESTPATTERN_EN to also exercise the pattern counter.
module tb_ad7960_responder;

  localparam int DW = 18;
  localparam int TC = 36;

  logic          fast_clk_i = 1'b0;
  logic          buffer_reset_s = 1'b1;
  logic          cnv_i = 1'b0;
  logic          clk_en_i = 1'b0;
  logic [DW-1:0] sample_data_i = '0;
  logic          d_o, dco_o, busy_o, sample_taken_o, overrun_o;

  ad7960_responder #(.DATA_W(DW), .TCONV_CYC(TC)) dut (
    .fast_clk_i     (fast_clk_i),
    .buffer_reset_s (buffer_reset_s),
    .cnv_i          (cnv_i),
    .clk_en_i       (clk_en_i),
    .sample_data_i  (sample_data_i),
    .d_o            (d_o),
    .dco_o          (dco_o),
    .busy_o         (busy_o),
    .sample_taken_o (sample_taken_o),
    .overrun_o      (overrun_o)
  );

  always #5 fast_clk_i = ~fast_clk_i;

  typedef struct {
    logic [DW-1:0] sample;
    int            n_en;
    bit            gap;
    int            exp_p;
  } vec_t;

  vec_t          vecs[5];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  int            pulses = 0;
  int            nbits = 0;
  logic [DW-1:0] word = '0;
  logic [DW-1:0] last_cap = '0;
  int            pat_model = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Deserialise every echoed clock into words and score them.
  always @(negedge fast_clk_i) begin
    #1;
    if (buffer_reset_s) begin
      nbits = 0;
      word  = '0;
    end else if (dco_o) begin
      word = {word[DW-2:0], d_o};
      nbits++;
      pulses++;
      if (nbits == DW) begin
        nbits = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL word: got %0h, none expected", word);
        end else begin
          check("word", int'(word), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge fast_clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_cap(input logic [DW-1:0] s);
`ifdef AD7960_TESTPATTERN_EN
    return DW'(pat_model);
`else
    return s;
`endif
  endfunction

  task automatic do_reset();
    buffer_reset_s = 1'b1;
    cnv_i = 1'b0;
    clk_en_i = 1'b0;
    tick();
    check("rst d_o", d_o, 0);
    check("rst dco_o", dco_o, 0);
    check("rst busy", busy_o, 0);
    check("rst taken", sample_taken_o, 0);
    check("rst overrun", overrun_o, 0);
    buffer_reset_s = 1'b0;
    pat_model = 0;
    tick();
    tick();
  endtask

  task automatic cnv_start(input logic [DW-1:0] s);
    sample_data_i = s;
    cnv_i = 1'b1;
    tick();
    cnv_i = 1'b0;
    tick();
    last_cap = exp_cap(s);
    pat_model = (pat_model + 1) & 32'h3FFFF;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic read_bits(input int n_en, input bit gap, input int exp_p);
    int p0;
    p0 = pulses;
    if (exp_p == DW) exp_q.push_back(last_cap);
    for (int i = 0; i < n_en; i++) begin
      clk_en_i = 1'b1;
      tick();
      if (gap) begin
        clk_en_i = 1'b0;
        tick();
      end
    end
    clk_en_i = 1'b0;
    repeat (3) tick();
    check("pulse count", pulses - p0, exp_p);
    check("d_o idle", d_o, 0);
    check("busy idle", busy_o, 0);
  endtask

  task automatic run_rest(input int n_en, input bit gap, input int exp_p);
    int n;
    check("taken pulse", sample_taken_o, 1);
    check("busy conv", busy_o, 1);
    tick();
    check("taken 1cyc", sample_taken_o, 0);
    wait_ready(n);
    check("tconv", n, TC - 1);
    read_bits(n_en, gap, exp_p);
  endtask

  task automatic run_conv(input logic [DW-1:0] s, input int n_en,
                          input bit gap, input int exp_p);
    cnv_start(s);
    run_rest(n_en, gap, exp_p);
  endtask

  initial begin
    int n;
    int p0;
    vecs[0] = '{18'h2A5C3, 18, 1'b0, 18};
    vecs[1] = '{18'h3FFFF, 20, 1'b0, 18};
    vecs[2] = '{18'h00001, 18, 1'b1, 18};
    vecs[3] = '{18'h20000, 19, 1'b1, 18};
    vecs[4] = '{18'h15555, 18, 1'b0, 18};

    do_reset();
    foreach (vecs[i]) begin
      run_conv(vecs[i].sample, vecs[i].n_en, vecs[i].gap, vecs[i].exp_p);
      check("no overrun", overrun_o, 0);
    end

    // Second CNV ten cycles into a conversion is ignored but flagged.
    do_reset();
    cnv_start(18'h1F0F0);
    check("ovr taken", sample_taken_o, 1);
    repeat (10) tick();
    sample_data_i = 18'h0ABCD;
    cnv_i = 1'b1;
    tick();
    cnv_i = 1'b0;
    tick();
    check("ovr ignored", sample_taken_o, 0);
    check("ovr flag conv", overrun_o, 1);
    check("ovr busy", busy_o, 1);
    wait_ready(n);
    read_bits(18, 1'b0, 18);

    // CNV mid-SHIFT drops the word and restarts.
    do_reset();
    cnv_start(18'h3C3C3);
    tick();
    wait_ready(n);
    clk_en_i = 1'b1;
    repeat (5) tick();
    clk_en_i = 1'b0;
    cnv_start(18'h12345);
    nbits = 0;
    word = '0;
    check("ovr flag shift", overrun_o, 1);
    run_rest(18, 1'b0, 18);

    // CNV rise and clk_en together in READY: restart wins, no bit shifted.
    do_reset();
    cnv_start(18'h0F00F);
    tick();
    wait_ready(n);
    p0 = pulses;
    sample_data_i = 18'h2BEEF;
    cnv_i = 1'b1;
    tick();
    clk_en_i = 1'b1;
    tick();
    clk_en_i = 1'b0;
    cnv_i = 1'b0;
    last_cap = exp_cap(18'h2BEEF);
    pat_model = (pat_model + 1) & 32'h3FFFF;
    check("prio overrun", overrun_o, 1);
    check("prio d_o", d_o, 0);
    run_rest(18, 1'b0, 18);
    check("prio pulses", pulses - p0, 18);

    // Reset after bit 7 aborts the transfer immediately.
    do_reset();
    cnv_start(18'h2A5C3);
    tick();
    wait_ready(n);
    clk_en_i = 1'b1;
    repeat (7) tick();
    p0 = pulses;
    buffer_reset_s = 1'b1;
    #1;
    check("mid rst d_o", d_o, 0);
    check("mid rst dco", dco_o, 0);
    check("mid rst busy", busy_o, 0);
    check("mid rst taken", sample_taken_o, 0);
    repeat (3) tick();
    check("mid rst pulses", pulses - p0, 0);
    buffer_reset_s = 1'b0;
    clk_en_i = 1'b0;
    pat_model = 0;
    tick();
    run_conv(18'h1D2E3, 18, 1'b0, 18);

`ifdef AD7960_TESTPATTERN_EN
    do_reset();
    for (int i = 0; i < 3; i++) run_conv(18'h00000, 18, 1'b0, 18);
    force dut.pat_cnt = 18'h3FFFF;
    tick();
    release dut.pat_cnt;
    pat_model = 32'h3FFFF;
    run_conv(18'h00000, 18, 1'b0, 18);
    run_conv(18'h00000, 18, 1'b0, 18);
`endif

    repeat (4) tick();
    check("queue drained", exp_q.size(), 0);
    check("no partial", nbits, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
